// File: rtl/i2c_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : i2c_cmd_seq
// Purpose  : Command sequencer placed directly upstream of i2c_master.
//            Queued register transactions are buffered in a command FIFO and
//            launched one at a time on the master's inputs. An arbitration
//            loss relaunches the same command up to MAX_RETRY times. Exactly
//            one response (data + status) is returned per accepted command,
//            in command order.
// Ports    : clk, rst (async, active-low)
//            cmd_*      : command push interface (valid/ready)
//            rsp_*      : response interface (valid/ready), status
//                         00 ok, 01 nack, 10 arb lost, 11 timeout
//            m_*        : launch/completion handshake with i2c_master
//            idle       : FIFO empty, FSM idle, no response pending
// Revision : 1.0 - initial release
// ============================================================================
module i2c_cmd_seq #(
   parameter int FIFO_DEPTH     = 8,
   parameter int MAX_RETRY      = 3,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [6:0] cmd_addr7,
   input  logic [7:0] cmd_reg,
   input  logic [7:0] cmd_data,
   input  logic       cmd_read,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic [1:0] rsp_status,
   output logic       m_start,
   output logic       m_rw,
   output logic       m_do_read,
   output logic [6:0] m_addr7,
   output logic [7:0] m_reg_addr,
   output logic [7:0] m_data_in,
   input  logic       m_busy,
   input  logic       m_done,
   input  logic       m_ack_err,
   input  logic       m_arb_lost,
   input  logic [7:0] m_read_data,
   output logic       idle
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int RW = (MAX_RETRY > 0)      ? $clog2(MAX_RETRY + 1)      : 1;
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int GW = (GAP_CYCLES > 0)     ? $clog2(GAP_CYCLES + 1)     : 1;

   localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(FIFO_DEPTH);
   localparam logic [RW-1:0] RETRY_W  = RW'(MAX_RETRY);
   localparam logic [TW-1:0] TMO_LD   = TW'(TIMEOUT_CYCLES);
   localparam logic [GW-1:0] GAP_LD   = GW'(GAP_CYCLES);

   typedef struct packed {
      logic [6:0] addr7;
      logic [7:0] reg_addr;
      logic [7:0] data;
      logic       read;
   } cmd_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LAUNCH    = 3'd1,
      WAIT_DONE = 3'd2,
      RESP      = 3'd3,
      GAP       = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // Command FIFO
   // ------------------------------------------------------------------
   cmd_t          mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   cmd_t          head;
   state_t        state;

   assign cmd_ready = (count != DEPTH_W);
   assign push      = cmd_valid && cmd_ready;
   // The head is only taken when the master is free, so a command never
   // launches on top of an abandoned (timed-out) transfer.
   assign pop       = (state == IDLE) && (count != '0) && !m_busy;
   assign head      = mem[rd_ptr];
   assign idle      = (count == '0) && (state == IDLE) && !rsp_valid;

   // Storage carries no reset: entries are only read once counted valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{addr7: cmd_addr7, reg_addr: cmd_reg,
                          data: cmd_data, read: cmd_read};
      end
   end

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Sequencer FSM
   // ------------------------------------------------------------------
   logic [RW-1:0] retry_cnt;
   logic          retry_pend;
   logic [TW-1:0] tmo_cnt;
   logic [GW-1:0] gap_cnt;
   logic [7:0]    res_data;
   logic [1:0]    res_status;

   assign m_do_read = m_rw;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         m_start    <= 1'b0;
         m_rw       <= 1'b0;
         m_addr7    <= '0;
         m_reg_addr <= '0;
         m_data_in  <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_status <= '0;
         retry_cnt  <= '0;
         retry_pend <= 1'b0;
         tmo_cnt    <= '0;
         gap_cnt    <= '0;
         res_data   <= '0;
         res_status <= '0;
      end else begin
         m_start <= 1'b0;
         if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (pop) begin
                  m_addr7    <= head.addr7;
                  m_reg_addr <= head.reg_addr;
                  m_data_in  <= head.data;
                  m_rw       <= head.read;
                  retry_cnt  <= '0;
                  state      <= LAUNCH;
               end
            end

            LAUNCH: begin
               m_start <= 1'b1;
               tmo_cnt <= TMO_LD;
               state   <= WAIT_DONE;
            end

            WAIT_DONE: begin
               if (m_done) begin
                  res_data <= 8'h00;
                  if (m_arb_lost && (retry_cnt < RETRY_W)) begin
                     // Relaunch the same latched command after a gap.
                     retry_cnt  <= retry_cnt + 1'b1;
                     retry_pend <= 1'b1;
                     gap_cnt    <= GAP_LD;
                     state      <= GAP;
                  end else begin
                     state <= RESP;
                     if (m_arb_lost) begin
                        res_status <= 2'b10;
                     end else if (m_ack_err) begin
                        res_status <= 2'b01;
                     end else begin
                        res_status <= 2'b00;
                        if (m_rw) res_data <= m_read_data;
                     end
                  end
               end else if (TIMEOUT_CYCLES != 0) begin
                  if (tmo_cnt <= TW'(1)) begin
                     res_status <= 2'b11;
                     res_data   <= 8'h00;
                     state      <= RESP;
                  end else begin
                     tmo_cnt <= tmo_cnt - 1'b1;
                  end
               end
            end

            // Stalls here while a previous response is still unconsumed.
            RESP: begin
               if (!rsp_valid || rsp_ready) begin
                  rsp_valid  <= 1'b1;
                  rsp_data   <= res_data;
                  rsp_status <= res_status;
                  retry_pend <= 1'b0;
                  gap_cnt    <= GAP_LD;
                  state      <= GAP;
               end
            end

            // A zero or one cycle gap both leave after a single cycle.
            GAP: begin
               if (gap_cnt <= GW'(1)) begin
                  state <= retry_pend ? LAUNCH : IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_cmd_seq
// Purpose  : Self-checking bench for i2c_cmd_seq with a behavioural stub of
//            i2c_master. Each queued command carries a script (number of
//            arbitration losses, NACK flag, read byte); expected responses
//            and launch counts are derived from the command rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_cmd_seq;

   localparam int MAX_RETRY  = 3;
   localparam int GAP_CYCLES = 16;
   localparam int DEPTH      = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [6:0] cmd_addr7 = '0;
   logic [7:0] cmd_reg = '0;
   logic [7:0] cmd_data = '0;
   logic       cmd_read = 1'b0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_data;
   logic [1:0] rsp_status;
   logic       m_start, m_rw, m_do_read;
   logic [6:0] m_addr7;
   logic [7:0] m_reg_addr, m_data_in;
   logic       m_busy;
   logic       m_done = 1'b0;
   logic       m_ack_err = 1'b0;
   logic       m_arb_lost = 1'b0;
   logic [7:0] m_read_data = '0;
   logic       idle;

   logic hold_busy = 1'b0;
   logic s_busy = 1'b0;
   assign m_busy = hold_busy | s_busy;

   always #5 clk = ~clk;

   i2c_cmd_seq #(
      .FIFO_DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY),
      .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(0)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr7(cmd_addr7),
      .cmd_reg(cmd_reg), .cmd_data(cmd_data), .cmd_read(cmd_read),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_status(rsp_status),
      .m_start(m_start), .m_rw(m_rw), .m_do_read(m_do_read),
      .m_addr7(m_addr7), .m_reg_addr(m_reg_addr), .m_data_in(m_data_in),
      .m_busy(m_busy), .m_done(m_done), .m_ack_err(m_ack_err),
      .m_arb_lost(m_arb_lost), .m_read_data(m_read_data), .idle(idle)
   );

   typedef struct packed {
      logic [6:0] addr7;
      logic [7:0] rg;
      logic [7:0] data;
      logic       rd;
      logic [2:0] arb;    // number of consecutive arbitration losses
      logic       nack;
      logic [7:0] rdata;
   } cmd_t;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] st;
      logic [2:0] starts;
   } rsp_t;

   cmd_t mq[$];          // commands not yet finished by the stub master
   rsp_t eq[$];          // expected responses, in push order
   int   act_starts[$];  // launches observed per finished command
   int   gap_q[$];       // idle cycles between an arb-lost done and relaunch

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int total_starts = 0;
   int last_start_cyc = 0;
   int force_lat = 0;
   int rdy_mode = 1;     // 0: never ready, 1: always ready, 2: random

   always @(posedge clk) cyc <= cyc + 1;

   // Expected outcome of one command, straight from the command rules.
   function automatic rsp_t expect_of(input cmd_t c);
      rsp_t r;
      if (int'(c.arb) > MAX_RETRY) begin
         r.st = 2'b10; r.data = 8'h00; r.starts = 3'(MAX_RETRY + 1);
      end else begin
         r.starts = 3'(int'(c.arb) + 1);
         if (c.nack) begin
            r.st = 2'b01; r.data = 8'h00;
         end else begin
            r.st = 2'b00; r.data = c.rd ? c.rdata : 8'h00;
         end
      end
      return r;
   endfunction

   function automatic cmd_t mk(input logic [6:0] a, input logic [7:0] rg,
                               input logic [7:0] d, input logic rd,
                               input int arb, input logic nack,
                               input logic [7:0] rdata);
      cmd_t c;
      c.addr7 = a; c.rg = rg; c.data = d; c.rd = rd;
      c.arb = 3'(arb); c.nack = nack; c.rdata = rdata;
      return c;
   endfunction

   // ------------------------------------------------------------------
   // Stub i2c_master
   // ------------------------------------------------------------------
   initial begin
      int   attempt;
      int   lat;
      int   done_cyc;
      logic active;
      logic retry_wait;
      attempt = 0; lat = 0; done_cyc = 0; active = 1'b0; retry_wait = 1'b0;
      forever begin
         @(posedge clk); #1;
         m_done = 1'b0; m_arb_lost = 1'b0; m_ack_err = 1'b0;
         m_read_data = 8'($urandom);
         if (!rst) begin
            active = 1'b0; s_busy = 1'b0; attempt = 0; retry_wait = 1'b0;
         end else if (m_start) begin
            total_starts++;
            last_start_cyc = cyc;
            if (retry_wait) begin
               gap_q.push_back(cyc - done_cyc - 1);
               retry_wait = 1'b0;
            end
            checks++;
            if (active || mq.size() == 0) begin
               errors++;
               $display("FAIL start_unexpected: m_start while active=%0b queued=%0d", active, mq.size());
            end else begin
               if (m_addr7 !== mq[0].addr7 || m_reg_addr !== mq[0].rg ||
                   m_rw !== mq[0].rd || m_do_read !== mq[0].rd ||
                   (!mq[0].rd && m_data_in !== mq[0].data)) begin
                  errors++;
                  $display("FAIL start_fields: got %h/%h/%h rw=%b rd=%b, want %h/%h/%h rw=%b",
                           m_addr7, m_reg_addr, m_data_in, m_rw, m_do_read,
                           mq[0].addr7, mq[0].rg, mq[0].data, mq[0].rd);
               end
               active = 1'b1; s_busy = 1'b1; attempt++;
               lat = (force_lat != 0) ? force_lat : $urandom_range(2, 6);
            end
         end else if (active) begin
            lat--;
            if (lat == 0) begin
               checks++;
               if (m_addr7 !== mq[0].addr7 || m_reg_addr !== mq[0].rg || m_rw !== mq[0].rd) begin
                  errors++;
                  $display("FAIL held_fields: got %h/%h rw=%b, want %h/%h rw=%b",
                           m_addr7, m_reg_addr, m_rw, mq[0].addr7, mq[0].rg, mq[0].rd);
               end
               m_done = 1'b1; s_busy = 1'b0; active = 1'b0;
               if (attempt <= int'(mq[0].arb)) begin
                  m_arb_lost = 1'b1;
                  m_ack_err  = 1'($urandom);   // arb loss must take priority
               end else begin
                  m_ack_err = mq[0].nack;
                  if (mq[0].rd) m_read_data = mq[0].rdata;
               end
               if (attempt > int'(mq[0].arb) || attempt > MAX_RETRY) begin
                  act_starts.push_back(attempt);
                  void'(mq.pop_front());
                  attempt = 0;
               end else begin
                  retry_wait = 1'b1;
                  done_cyc = cyc;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Response ready driver and response scoreboard
   // ------------------------------------------------------------------
   initial forever begin
      @(posedge clk); #1;
      rsp_ready = (rdy_mode == 2) ? ($urandom_range(0, 2) != 0) : (rdy_mode == 1);
   end

   initial begin
      rsp_t e;
      int   s;
      forever begin
         @(negedge clk);
         if (rst && rsp_valid && rsp_ready) begin
            checks++;
            if (eq.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected: data=%h status=%b", rsp_data, rsp_status);
            end else begin
               e = eq.pop_front();
               s = (act_starts.size() != 0) ? act_starts.pop_front() : -1;
               if (rsp_data !== e.data || rsp_status !== e.st || s != int'(e.starts)) begin
                  errors++;
                  $display("FAIL rsp: got data=%h status=%b starts=%0d, want data=%h status=%b starts=%0d",
                           rsp_data, rsp_status, s, e.data, e.st, e.starts);
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic push_cmd(input cmd_t c, output int acc_cyc);
      int budget;
      budget = 3000;
      acc_cyc = -1;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_addr7 = c.addr7; cmd_reg = c.rg;
      cmd_data = c.data; cmd_read = c.rd;
      forever begin
         @(negedge clk);
         if (cmd_ready) begin
            mq.push_back(c);
            eq.push_back(expect_of(c));
            @(posedge clk); #1;
            acc_cyc = cyc;
            break;
         end
         budget--;
         if (budget == 0) begin
            checks++; errors++;
            $display("FAIL push_timeout: cmd_ready=%b, required 1", cmd_ready);
            break;
         end
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_start(input int base, input string name);
      int n;
      n = 0;
      while (total_starts == base && n < 200) begin
         @(posedge clk); #2; n++;
      end
      checks++;
      if (total_starts == base) begin
         errors++;
         $display("FAIL %s_start: starts=%0d, required more than %0d", name, total_starts, base);
      end
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while (!(eq.size() == 0 && idle === 1'b1) && n < budget) begin
         @(posedge clk); #2; n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_drain: pending=%0d idle=%b, required 0 and 1", name, eq.size(), idle);
      end
   endtask

   // ------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({cmd_ready, idle, rsp_valid, m_start} !== 4'b1100) begin
         errors++;
         $display("FAIL reset_flags: ready/idle/rsp_valid/start=%b, required 1100",
                  {cmd_ready, idle, rsp_valid, m_start});
      end
      checks++;
      if ({m_rw, m_do_read, m_addr7, m_reg_addr, m_data_in, rsp_data, rsp_status} !== '0) begin
         errors++;
         $display("FAIL reset_data: m=%h/%h/%h rsp=%h/%b, required all zero",
                  m_addr7, m_reg_addr, m_data_in, rsp_data, rsp_status);
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({cmd_ready, idle, rsp_valid} !== 3'b110) begin
         errors++;
         $display("FAIL reset_release: ready/idle/rsp_valid=%b, required 110", {cmd_ready, idle, rsp_valid});
      end
   endtask

   task automatic test_write();
      int acc, base;
      rdy_mode = 1;
      base = total_starts;
      push_cmd(mk(7'h42, 8'h01, 8'hA5, 1'b0, 0, 1'b0, 8'h00), acc);
      wait_start(base, "write");
      checks++;
      if (last_start_cyc - acc != 2) begin
         errors++;
         $display("FAIL write_latency: %0d cycles push to m_start, required 2", last_start_cyc - acc);
      end
      checks++;
      if ({m_rw, m_addr7, m_reg_addr, m_data_in} !== {1'b0, 7'h42, 8'h01, 8'hA5}) begin
         errors++;
         $display("FAIL write_fields: rw=%b %h/%h/%h, required 0 42/01/a5", m_rw, m_addr7, m_reg_addr, m_data_in);
      end
      wait_drain("write", 300);
   endtask

   task automatic test_read();
      int acc, base;
      base = total_starts;
      push_cmd(mk(7'h42, 8'h01, 8'h00, 1'b1, 0, 1'b0, 8'hA5), acc);
      wait_start(base, "read");
      checks++;
      if ({m_do_read, m_rw} !== 2'b11) begin
         errors++;
         $display("FAIL read_flags: do_read/rw=%b, required 11", {m_do_read, m_rw});
      end
      wait_drain("read", 300);
   endtask

   task automatic test_nack();
      int acc, base;
      base = total_starts;
      push_cmd(mk(7'h50, 8'h10, 8'h3C, 1'b0, 0, 1'b1, 8'h00), acc);
      wait_drain("nack", 300);
      checks++;
      if (total_starts - base != 1) begin
         errors++;
         $display("FAIL nack_starts: %0d launches, required 1", total_starts - base);
      end
   endtask

   task automatic test_retry();
      int acc, base;
      gap_q.delete();
      base = total_starts;
      push_cmd(mk(7'h42, 8'h05, 8'h5A, 1'b0, 2, 1'b0, 8'h00), acc);
      wait_drain("retry_ok", 600);
      checks++;
      if (total_starts - base != 3) begin
         errors++;
         $display("FAIL retry_ok_starts: %0d launches, required 3", total_starts - base);
      end
      base = total_starts;
      push_cmd(mk(7'h42, 8'h06, 8'h00, 1'b1, 4, 1'b0, 8'h77), acc);
      wait_drain("retry_lost", 600);
      checks++;
      if (total_starts - base != 4) begin
         errors++;
         $display("FAIL retry_lost_starts: %0d launches, required 4", total_starts - base);
      end
      checks++;
      if (gap_q.size() != 5) begin
         errors++;
         $display("FAIL retry_gap_count: %0d relaunches measured, required 5", gap_q.size());
      end
      foreach (gap_q[i]) begin
         checks++;
         if (gap_q[i] < GAP_CYCLES || gap_q[i] > GAP_CYCLES + 2) begin
            errors++;
            $display("FAIL retry_gap: %0d idle cycles, required %0d..%0d", gap_q[i], GAP_CYCLES, GAP_CYCLES + 2);
         end
      end
   endtask

   task automatic test_back_pressure();
      int acc, base, hits;
      hold_busy = 1'b1;
      rdy_mode = 0;
      base = total_starts;
      for (int i = 0; i < DEPTH; i++) begin
         push_cmd(mk(7'(8'h20 + i), 8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b0, 8'($urandom)), acc);
      end
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_ready: cmd_ready=%b after %0d pushes, required 0", cmd_ready, DEPTH);
      end
      // Offer a ninth command that must be refused.
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_addr7 = 7'h7F; cmd_reg = 8'hEE;
      hits = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (cmd_ready) hits++;
      end
      cmd_valid = 1'b0;
      checks++;
      if (hits != 0) begin
         errors++;
         $display("FAIL full_refuse: ninth push saw cmd_ready %0d times, required 0", hits);
      end
      hold_busy = 1'b0;
      repeat (100) @(posedge clk);
      #2;
      checks++;
      if (total_starts - base != 2 || rsp_valid !== 1'b1 || eq.size() != DEPTH) begin
         errors++;
         $display("FAIL stall: starts=%0d rsp_valid=%b pending=%0d, required 2 1 %0d",
                  total_starts - base, rsp_valid, eq.size(), DEPTH);
      end
      rdy_mode = 1;
      wait_drain("back_pressure", 2000);
   endtask

   task automatic test_random();
      int acc, arb;
      rdy_mode = 2;
      for (int i = 0; i < 24; i++) begin
         arb = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 4);
         push_cmd(mk(7'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), arb,
                     ($urandom_range(0, 3) == 0), 8'($urandom)), acc);
         repeat ($urandom_range(0, 20)) @(posedge clk);
      end
      wait_drain("random", 20000);
      rdy_mode = 1;
   endtask

   task automatic test_async_reset();
      int acc, base, seen;
      force_lat = 60;
      base = total_starts;
      push_cmd(mk(7'h42, 8'h09, 8'h99, 1'b0, 0, 1'b0, 8'h00), acc);
      wait_start(base, "async_reset");
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, idle, rsp_valid, m_start, m_rw} !== 5'b11000 ||
          {m_addr7, m_reg_addr, m_data_in} !== '0) begin
         errors++;
         $display("FAIL async_reset_now: ready/idle/rsp/start/rw=%b m=%h/%h/%h, required 11000 and zero",
                  {cmd_ready, idle, rsp_valid, m_start, m_rw}, m_addr7, m_reg_addr, m_data_in);
      end
      mq.delete(); eq.delete(); act_starts.delete();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      force_lat = 0;
      @(negedge clk);
      checks++;
      if ({cmd_ready, idle} !== 2'b11) begin
         errors++;
         $display("FAIL async_reset_release: ready/idle=%b, required 11", {cmd_ready, idle});
      end
      base = total_starts;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      checks++;
      if (seen != 0 || total_starts != base) begin
         errors++;
         $display("FAIL async_reset_quiet: rsp_valid cycles=%0d new starts=%0d, required 0 0",
                  seen, total_starts - base);
      end
      // The sequencer must still work normally afterwards.
      push_cmd(mk(7'h42, 8'h0A, 8'h00, 1'b1, 1, 1'b0, 8'hC3), acc);
      wait_drain("after_reset", 600);
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_nack();
      test_retry();
      test_back_pressure();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
